// File: rtl/left_path_pkg.sv
// Shared types and helpers for the left-camera pixel path.
// Combinational only: no latency.
// No flow control of its own.
package left_path_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        REQ  = 2'd1,
        SEND = 2'd2
    } state_t;

    localparam int BYTES_PER_WORD  = 4;
    localparam int BYTES_PER_PIXEL = 2;

    // RGB888 -> RGB565 by plain truncation of each channel
    function automatic logic [15:0] rgb888_to_565(input logic [23:0] px);
        return {px[23:19], px[15:10], px[7:3]};
    endfunction

    // Bytes occupied by one frame once packed as RGB565
    function automatic int frame_bytes(input int pixels);
        return pixels * BYTES_PER_PIXEL;
    endfunction

endpackage

// File: rtl/left_burst_buf.sv
// BURST_LEN x 32 burst staging register file.
// Write lands on the rising edge; read port is combinational.
// No backpressure: the caller sequences writes and reads.
module left_burst_buf
    import left_path_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
)(
    input  logic             clk,
    input  logic             we,
    input  logic [IDX_W-1:0] wptr,
    input  logic [31:0]      wdata,
    input  logic [IDX_W-1:0] rptr,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // Store one packed pixel pair per write strobe
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wptr] <= wdata;
        end
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/left_fifo_ddr_writer.sv
// Pops RGB888 pixels, packs RGB565 pairs into a burst buffer and writes bursts to DDR.
// Pixel data is consumed 1 cycle after each pop; one burst is requested after BURST_LEN words fill.
// Pops stop while empty or while a burst is requested/sent; words hold while wr_ready=0.
module left_fifo_ddr_writer
    import left_path_pkg::*;
#(
    parameter int                BURST_LEN    = 16,
    parameter int                ADDR_W       = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = '0,
    parameter int                FRAME_PIXELS = 921600
)(
    input  logic              clk,
    input  logic              rst,
    output logic              fifo_rd_en,
    input  logic [23:0]       fifo_rd_data,
    input  logic              fifo_empty,
    input  logic              frame_start,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_len,
    input  logic              wr_ack,
    output logic [31:0]       wr_data,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic              wr_last,
    output logic              frame_done
);

    localparam int IDX_W       = $clog2(BURST_LEN);
    localparam int PTR_W       = IDX_W + 1;
    localparam int CNT_W       = IDX_W + 2;
    localparam int FRAME_BYTES = frame_bytes(FRAME_PIXELS);

    localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * BYTES_PER_WORD);
    localparam logic [ADDR_W-1:0] FRAME_END   = BASE_ADDR + ADDR_W'(FRAME_BYTES);
    localparam logic [CNT_W-1:0]  PIX_PER_BURST = CNT_W'(2 * BURST_LEN);
    localparam logic [PTR_W-1:0]  WORDS_FULL    = PTR_W'(BURST_LEN);
    localparam logic [IDX_W-1:0]  LAST_IDX      = IDX_W'(BURST_LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  issued_cnt;
    logic [PTR_W-1:0]  wptr;
    logic [IDX_W-1:0]  rptr;
    logic              rd_pend;
    logic              half_vld;
    logic [15:0]       half_px;
    logic              fs_pend;
    logic [ADDR_W-1:0] addr;
    logic              done_r;

    logic              rsp_take;
    logic              buf_we;
    logic [31:0]       buf_wdata;
    logic [31:0]       buf_rdata;
    logic              xfer;
    logic              last_xfer;
    logic [ADDR_W-1:0] addr_nxt;

    // A response is dropped when a frame restart lands in the same cycle
    assign rsp_take  = rd_pend && (state == FILL) && !frame_start;
    assign buf_we    = rsp_take && half_vld;
    assign buf_wdata = {rgb888_to_565(fifo_rd_data), half_px};
    assign xfer      = (state == SEND) && wr_ready;
    assign last_xfer = xfer && (rptr == LAST_IDX);
    assign addr_nxt  = addr + BURST_BYTES;

    assign wr_addr    = addr;
    assign wr_len     = 8'(BURST_LEN);
    assign frame_done = done_r;

    left_burst_buf #(
        .DEPTH (BURST_LEN)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .wptr  (wptr[IDX_W-1:0]),
        .wdata (buf_wdata),
        .rptr  (rptr),
        .rdata (buf_rdata)
    );

    // Next-state and handshake outputs; pops are masked in reset and on a frame restart
    always_comb begin
        state_nxt  = state;
        fifo_rd_en = 1'b0;
        wr_req     = 1'b0;
        wr_valid   = 1'b0;
        wr_last    = 1'b0;
        wr_data    = '0;
        case (state)
            FILL: begin
                fifo_rd_en = !rst && !fifo_empty && !frame_start && (issued_cnt < PIX_PER_BURST);
                if (!frame_start && (wptr == WORDS_FULL) && !rd_pend) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                wr_req = 1'b1;
                if (wr_ack) begin
                    state_nxt = SEND;
                end
            end
            SEND: begin
                wr_valid = 1'b1;
                wr_data  = buf_rdata;
                wr_last  = (rptr == LAST_IDX);
                if (last_xfer) begin
                    state_nxt = FILL;
                end
            end
            default: state_nxt = FILL;
        endcase
    end

    // State, counters, pixel pairing and frame address tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            issued_cnt <= '0;
            wptr       <= '0;
            rptr       <= '0;
            rd_pend    <= 1'b0;
            half_vld   <= 1'b0;
            half_px    <= '0;
            fs_pend    <= 1'b0;
            addr       <= BASE_ADDR;
            done_r     <= 1'b0;
        end else begin
            state   <= state_nxt;
            done_r  <= 1'b0;
            rd_pend <= fifo_rd_en;

            if (fifo_rd_en) begin
                issued_cnt <= issued_cnt + 1'b1;
            end

            if (rsp_take) begin
                if (!half_vld) begin
                    half_px  <= rgb888_to_565(fifo_rd_data);
                    half_vld <= 1'b1;
                end else begin
                    half_vld <= 1'b0;
                    wptr     <= wptr + 1'b1;
                end
            end

            if ((state == REQ) && wr_ack) begin
                rptr <= '0;
            end
            if (xfer) begin
                rptr <= rptr + 1'b1;
            end

            // Restart while filling: abandon the partial burst at once
            if ((state == FILL) && frame_start) begin
                addr       <= BASE_ADDR;
                issued_cnt <= '0;
                wptr       <= '0;
                half_vld   <= 1'b0;
            end

            // Restart while the burst is out: remember it until the burst ends
            if ((state != FILL) && frame_start) begin
                fs_pend <= 1'b1;
            end

            if (last_xfer) begin
                issued_cnt <= '0;
                wptr       <= '0;
                half_vld   <= 1'b0;
                fs_pend    <= 1'b0;
                if (fs_pend || frame_start) begin
                    addr <= BASE_ADDR;
                end else if (addr_nxt == FRAME_END) begin
                    addr   <= BASE_ADDR;
                    done_r <= 1'b1;
                end else begin
                    addr <= addr_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_left_fifo_ddr_writer.sv
// Randomized bench for left_fifo_ddr_writer against a queue-based reference model.
// Small frame (64 pixels) so address wrap and frame_done are reached quickly.
// wr_ready patterns: always high, alternating, random.
module tb_left_fifo_ddr_writer;

    localparam int          BL   = 16;
    localparam int          AW   = 28;
    localparam logic [27:0] BASE = 28'h100;
    localparam int          FP   = 64;
    localparam logic [27:0] FEND = BASE + 28'(FP * 2);

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_rd_en;
    logic [23:0] fifo_rd_data;
    logic        fifo_empty;
    logic        frame_start;
    logic        wr_req;
    logic [27:0] wr_addr;
    logic [7:0]  wr_len;
    logic        wr_ack;
    logic [31:0] wr_data;
    logic        wr_valid;
    logic        wr_ready;
    logic        wr_last;
    logic        frame_done;

    always #5 clk = ~clk;

    left_fifo_ddr_writer #(
        .BURST_LEN    (BL),
        .ADDR_W       (AW),
        .BASE_ADDR    (BASE),
        .FRAME_PIXELS (FP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .fifo_empty   (fifo_empty),
        .frame_start  (frame_start),
        .wr_req       (wr_req),
        .wr_addr      (wr_addr),
        .wr_len       (wr_len),
        .wr_ack       (wr_ack),
        .wr_data      (wr_data),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_last      (wr_last),
        .frame_done   (frame_done)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Source FIFO: data appears one cycle after a pop
    logic [23:0] src [0:4095];
    int          head = 0;
    int          tail = 0;
    logic [23:0] exp_px [$];

    assign fifo_empty = (head == tail);

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            if (head < tail) begin
                fifo_rd_data <= src[head];
                exp_px.push_back(src[head]);
                head <= head + 1;
            end else begin
                fifo_rd_data <= 24'hDEAD00;
            end
        end
    end

    // Reference model state
    logic [27:0] exp_addr  = BASE;
    bit          fs_pend_m = 1'b0;
    int          exp_fd    = 0;
    int          fd_seen   = 0;

    always @(negedge clk) begin
        if (fifo_empty && !rst) chk("pop_when_empty", fifo_rd_en, 1'b0);
        if (frame_done) fd_seen++;
    end

    function automatic logic [15:0] m565(input logic [23:0] p);
        int r, g, b;
        r = (int'(p) >> 19) & 31;
        g = (int'(p) >> 10) & 63;
        b = (int'(p) >> 3) & 31;
        return 16'(r * 2048 + g * 32 + b);
    endfunction

    task automatic push_px(input logic [23:0] v);
        src[tail] = v;
        tail++;
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) push_px(24'($urandom));
    endtask

    task automatic wait_head(input int target);
        int w = 0;
        while (head < target && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk("head_reached", head, target);
    endtask

    task automatic chk_reset_outs();
        chk("rst_rd_en", fifo_rd_en, 1'b0);
        chk("rst_req", wr_req, 1'b0);
        chk("rst_valid", wr_valid, 1'b0);
        chk("rst_last", wr_last, 1'b0);
        chk("rst_data", wr_data, 32'h0);
        chk("rst_done", frame_done, 1'b0);
        chk("rst_addr", wr_addr, BASE);
        chk("rst_len", wr_len, 8'(BL));
    endtask

    // mode: 0 ready high, 1 alternating starting high, 2 random
    // fs_at / rst_at: SEND cycle at which to pulse frame_start / assert reset (-1 = never)
    task automatic run_burst(input int mode, input int ack_dly, input int fs_at, input int rst_at);
        logic [31:0] words [BL];
        logic [31:0] prev_dat;
        logic [23:0] p0, p1;
        logic [27:0] nxt;
        bit          have_prev;
        bit          rdy;
        bit          expd;
        int          w, idx, cyc;

        w = 0;
        while (!wr_req && w < 600) begin
            @(negedge clk);
            w++;
        end
        chk("req_seen", wr_req, 1'b1);
        if (!wr_req) return;

        chk("req_pixels", exp_px.size(), 2 * BL);
        for (int i = 0; i < BL; i++) begin
            p0 = (exp_px.size() > 0) ? exp_px.pop_front() : 24'h0;
            p1 = (exp_px.size() > 0) ? exp_px.pop_front() : 24'h0;
            words[i] = {m565(p1), m565(p0)};
        end
        chk("req_addr", wr_addr, exp_addr);
        chk("req_len", wr_len, 8'(BL));
        chk("req_no_valid", wr_valid, 1'b0);

        for (int d = 0; d < ack_dly; d++) begin
            @(negedge clk);
            chk("req_hold", wr_req, 1'b1);
            chk("addr_hold", wr_addr, exp_addr);
        end
        wr_ack = 1'b1;
        @(negedge clk);
        wr_ack = 1'b0;
        chk("req_drop", wr_req, 1'b0);

        idx = 0;
        cyc = 0;
        have_prev = 1'b0;
        prev_dat = '0;
        while (idx < BL && cyc < 300) begin
            if (cyc == rst_at) begin
                #2 rst = 1'b1;
                #1 chk_reset_outs();
                @(negedge clk);
                @(negedge clk);
                rst = 1'b0;
                wr_ready = 1'b0;
                frame_start = 1'b0;
                exp_px.delete();
                exp_addr = BASE;
                fs_pend_m = 1'b0;
                return;
            end
            if (cyc == fs_at) begin
                frame_start = 1'b1;
                fs_pend_m = 1'b1;
            end else begin
                frame_start = 1'b0;
            end
            rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            wr_ready = rdy;
            chk("send_valid", wr_valid, 1'b1);
            if (have_prev) chk("data_stable", wr_data, prev_dat);
            chk("send_data", wr_data, words[idx]);
            chk("send_last", wr_last, (idx == BL - 1));
            if (rdy) begin
                idx++;
                have_prev = 1'b0;
            end else begin
                have_prev = 1'b1;
                prev_dat = wr_data;
            end
            cyc++;
            @(negedge clk);
        end
        wr_ready = 1'b0;
        frame_start = 1'b0;
        chk("burst_words", idx, BL);
        if (mode == 1) chk("toggle_cycles", cyc, 31);

        nxt = exp_addr + 28'(BL * 4);
        expd = 1'b0;
        if (fs_pend_m) begin
            exp_addr = BASE;
        end else if (nxt == FEND) begin
            exp_addr = BASE;
            expd = 1'b1;
        end else begin
            exp_addr = nxt;
        end
        fs_pend_m = 1'b0;
        if (expd) exp_fd++;

        chk("frame_done", frame_done, expd);
        chk("next_addr", wr_addr, exp_addr);
        @(negedge clk);
        chk("frame_done_pulse", frame_done, 1'b0);
        chk("valid_after", wr_valid, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        frame_start = 1'b0;
        wr_ack      = 1'b0;
        wr_ready    = 1'b0;

        @(negedge clk);
        chk_reset_outs();
        @(negedge clk);
        rst = 1'b0;

        // Fixed colour pattern: every word is {green565, red565}
        for (int i = 0; i < 2 * BL; i++) push_px((i % 2 == 0) ? 24'hFF0000 : 24'h00FF00);
        run_burst(0, 2, -1, -1);

        // Alternating ready; this burst closes the frame
        push_rand(2 * BL);
        run_burst(1, 1, -1, -1);

        // FIFO runs dry after 7 pixels for 10 cycles
        push_rand(7);
        wait_head(head + 7 - (head % 32 == 0 ? 0 : 0));
        for (int i = 0; i < 10; i++) @(negedge clk);
        chk("stall_head", head, tail);
        push_rand(2 * BL - 7);
        run_burst(2, 0, -1, -1);

        // frame_start while filling drops the 5 pixels already popped
        push_rand(5);
        wait_head(tail);
        @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        exp_px.delete();
        exp_addr = BASE;
        push_rand(2 * BL);
        run_burst(0, 3, -1, -1);

        // frame_start during SEND at the last burst of the frame: no frame_done
        push_rand(2 * BL);
        run_burst(2, 1, 5, -1);

        // frame_start during SEND at the first burst: address returns to base
        push_rand(2 * BL);
        run_burst(1, 2, 9, -1);

        // Reset in the middle of SEND
        push_rand(2 * BL);
        run_burst(0, 1, -1, 6);

        push_rand(2 * BL);
        run_burst(2, 0, -1, -1);

        for (int b = 0; b < 3; b++) begin
            push_rand(2 * BL);
            run_burst(2, $urandom_range(0, 3), -1, -1);
        end

        repeat (3) @(negedge clk);
        chk("frame_done_count", fd_seen, exp_fd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
